// File: rtl/fetch_flow_monitor_if.sv
// Bundles the run-control and fetch-stream signals observed by fetch_flow_monitor.
// The checker takes the slave modport, and the harness that drives the fetch stream takes the master modport.
interface fetch_flow_monitor_if #(
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CNT_W   = 16
);
    logic                    start;
    logic [FETCH_W-1:0]      fetch_fire;
    logic [FETCH_W*XLEN-1:0] fetch_pc;
    logic [FETCH_W-1:0]      fetch_invalid;
    logic                    redirect_valid;
    logic [XLEN-1:0]         redirect_pc;
    logic [2:0]              state_o;
    logic                    done;
    logic                    timeout;
    logic                    pc_err;
    logic [CNT_W-1:0]        err_count;
    logic [CNT_W-1:0]        fetch_count;
    logic [XLEN-1:0]         first_err_got;
    logic [XLEN-1:0]         first_err_exp;
    logic [XLEN-1:0]         expected_pc;

    modport master (
        output start, fetch_fire, fetch_pc, fetch_invalid, redirect_valid, redirect_pc,
        input  state_o, done, timeout, pc_err, err_count, fetch_count,
               first_err_got, first_err_exp, expected_pc
    );

    modport slave (
        input  start, fetch_fire, fetch_pc, fetch_invalid, redirect_valid, redirect_pc,
        output state_o, done, timeout, pc_err, err_count, fetch_count,
               first_err_got, first_err_exp, expected_pc
    );
endinterface

// File: rtl/fetch_flow_monitor.sv
// Run-control and PC-flow checker for a multi-lane fetch stage: checks fired PCs against the
// sequential/redirected stream, counts fetches and errors, drains on end of program, and has a watchdog.
module fetch_flow_monitor #(
    parameter int unsigned     FETCH_W      = 2,
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     PC_STEP      = 4,
    parameter longint unsigned RESET_PC     = 0,
    parameter int unsigned     DRAIN_CYCLES = 50,
    parameter int unsigned     MAX_CYCLES   = 1000,
    parameter int unsigned     CNT_W        = 16
) (
    input logic                 clk,
    input logic                 reset,
    fetch_flow_monitor_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_DRAIN   = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      cyc_q, cyc_d, drain_q, drain_d;
    logic [XLEN-1:0]  exp_pc_q, exp_pc_d, got_q, got_d, want_q, want_d;
    logic             seen_q, seen_d, pc_err_q, pc_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d, fetch_cnt_q, fetch_cnt_d;

    logic             inv_hit, contig_ok, any_mis, lane_err, wd_hit;
    logic [3:0]       fired_n, valid_n;
    logic [XLEN-1:0]  mis_got, mis_exp, lane_exp, lane_pc;
    logic [CNT_W:0]   fsum;
    logic [31:0]      cyc_inc, drain_inc;

    // Lanes at and above the first fired invalid lane are neither checked nor counted.
    always_comb begin
        inv_hit  = 1'b0;
        any_mis  = 1'b0;
        fired_n  = '0;
        valid_n  = '0;
        mis_got  = '0;
        mis_exp  = '0;
        lane_exp = '0;
        lane_pc  = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            lane_exp = exp_pc_q + XLEN'(i * PC_STEP);
            lane_pc  = bus.fetch_pc[i*XLEN +: XLEN];
            if (bus.fetch_fire[i]) begin
                fired_n = fired_n + 4'd1;
                if (bus.fetch_invalid[i]) inv_hit = 1'b1;
                if (!inv_hit) begin
                    valid_n = valid_n + 4'd1;
                    if ((lane_pc != lane_exp) && !any_mis) begin
                        any_mis = 1'b1;
                        mis_got = lane_pc;
                        mis_exp = lane_exp;
                    end
                end
            end
        end
        // A contiguous mask from lane 0 has no set bit that survives adding one.
        contig_ok = (bus.fetch_fire & (bus.fetch_fire + FETCH_W'(1))) == '0;
        lane_err  = any_mis || !contig_ok;
    end

    assign cyc_inc   = cyc_q + 32'd1;
    assign drain_inc = drain_q + 32'd1;
    assign wd_hit    = (cyc_inc == MAX_CYCLES);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: if (bus.start) state_d = S_RUN;
            S_RUN: begin
                if (wd_hit)       state_d = S_TIMEOUT;
                else if (inv_hit) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (wd_hit)                         state_d = S_TIMEOUT;
                else if (drain_inc == DRAIN_CYCLES) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_d       = cyc_q;
        drain_d     = drain_q;
        exp_pc_d    = exp_pc_q;
        got_d       = got_q;
        want_d      = want_q;
        seen_d      = seen_q;
        pc_err_d    = 1'b0;
        err_cnt_d   = err_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        fsum        = {1'b0, fetch_cnt_q} + (CNT_W+1)'(valid_n);
        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (bus.start) begin
                    cyc_d       = '0;
                    drain_d     = '0;
                    exp_pc_d    = XLEN'(RESET_PC);
                    got_d       = '0;
                    want_d      = '0;
                    seen_d      = 1'b0;
                    err_cnt_d   = '0;
                    fetch_cnt_d = '0;
                end
            end
            S_RUN: begin
                cyc_d       = cyc_inc;
                pc_err_d    = lane_err;
                fetch_cnt_d = fsum[CNT_W] ? '1 : fsum[CNT_W-1:0];
                if (lane_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
                if (any_mis && !seen_q) begin
                    seen_d = 1'b1;
                    got_d  = mis_got;
                    want_d = mis_exp;
                end
                // Lanes were checked against the old expected PC; a redirect only moves the next one.
                if (bus.redirect_valid) exp_pc_d = bus.redirect_pc;
                else                    exp_pc_d = exp_pc_q + XLEN'(32'(fired_n) * PC_STEP);
            end
            S_DRAIN: begin
                cyc_d   = cyc_inc;
                drain_d = drain_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            drain_q     <= '0;
            exp_pc_q    <= XLEN'(RESET_PC);
            got_q       <= '0;
            want_q      <= '0;
            seen_q      <= 1'b0;
            pc_err_q    <= 1'b0;
            err_cnt_q   <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            drain_q     <= drain_d;
            exp_pc_q    <= exp_pc_d;
            got_q       <= got_d;
            want_q      <= want_d;
            seen_q      <= seen_d;
            pc_err_q    <= pc_err_d;
            err_cnt_q   <= err_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign bus.state_o       = state_q;
    assign bus.done          = (state_q == S_DONE);
    assign bus.timeout       = (state_q == S_TIMEOUT);
    assign bus.pc_err        = pc_err_q;
    assign bus.err_count     = err_cnt_q;
    assign bus.fetch_count   = fetch_cnt_q;
    assign bus.first_err_got = got_q;
    assign bus.first_err_exp = want_q;
    assign bus.expected_pc   = exp_pc_q;
endmodule

// File: tb/tb_fetch_flow_monitor.sv
// Bench for fetch_flow_monitor: directed scenarios plus random fetch streams checked every cycle
// against a behavioural model; a second instance with a short watchdog covers the timeout path.
module tb_fetch_flow_monitor;
    localparam int FW      = 2;
    localparam int XL      = 32;
    localparam int CW      = 16;
    localparam int DRAIN_A = 6;
    localparam int MAX_A   = 1000;
    localparam int MAX_B   = 20;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_DRAIN = 2, ST_DONE = 3, ST_TO = 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_start, a_rv;
    logic [1:0]  a_fire, a_inv;
    logic [31:0] a_p0, a_p1, a_rpc;
    logic        b_rst_n, b_start;

    fetch_flow_monitor_if #(.FETCH_W(FW), .XLEN(XL), .CNT_W(CW)) bus_a ();
    fetch_flow_monitor_if #(.FETCH_W(FW), .XLEN(XL), .CNT_W(CW)) bus_b ();

    assign bus_a.start          = a_start;
    assign bus_a.fetch_fire     = a_fire;
    assign bus_a.fetch_pc       = {a_p1, a_p0};
    assign bus_a.fetch_invalid  = a_inv;
    assign bus_a.redirect_valid = a_rv;
    assign bus_a.redirect_pc    = a_rpc;

    assign bus_b.start          = b_start;
    assign bus_b.fetch_fire     = '0;
    assign bus_b.fetch_pc       = '0;
    assign bus_b.fetch_invalid  = '0;
    assign bus_b.redirect_valid = 1'b0;
    assign bus_b.redirect_pc    = '0;

    fetch_flow_monitor #(.FETCH_W(FW), .XLEN(XL), .PC_STEP(4), .RESET_PC(0), .DRAIN_CYCLES(DRAIN_A),
                         .MAX_CYCLES(MAX_A), .CNT_W(CW))
        dut_a (.clk(clk), .reset(a_rst_n), .bus(bus_a));

    fetch_flow_monitor #(.FETCH_W(FW), .XLEN(XL), .PC_STEP(4), .RESET_PC(0), .DRAIN_CYCLES(50),
                         .MAX_CYCLES(MAX_B), .CNT_W(CW))
        dut_b (.clk(clk), .reset(b_rst_n), .bus(bus_b));

    // scoreboard
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // behavioural reference model of instance A
    int          m_state, m_fc, m_ec, m_cyc, m_drain;
    logic [31:0] m_exp, m_got, m_want;
    bit          m_seen, m_pcerr;

    task automatic model_step();
        int          k, add;
        bit          err, stop, nxt_pcerr;
        logic [31:0] pc, lane_exp;
        nxt_pcerr = 1'b0;
        if (!a_rst_n) begin
            m_state = ST_IDLE; m_fc = 0; m_ec = 0; m_cyc = 0; m_drain = 0;
            m_exp = 0; m_got = 0; m_want = 0; m_seen = 0; m_pcerr = 0;
            return;
        end
        case (m_state)
            ST_RUN: begin
                k    = $countones(a_fire);
                err  = (a_fire != 2'((1 << k) - 1));
                stop = 1'b0;
                add  = 0;
                for (int i = 0; i < FW; i++) begin
                    if (a_fire[i]) begin
                        if (a_inv[i]) stop = 1'b1;
                        if (!stop) begin
                            pc       = (i == 0) ? a_p0 : a_p1;
                            lane_exp = m_exp + 32'(4 * i);
                            add++;
                            if (pc != lane_exp) begin
                                err = 1'b1;
                                if (!m_seen) begin m_seen = 1'b1; m_got = pc; m_want = lane_exp; end
                            end
                        end
                    end
                end
                if (err && m_ec < 65535) m_ec++;
                m_fc      = (m_fc + add > 65535) ? 65535 : m_fc + add;
                nxt_pcerr = err;
                m_exp     = a_rv ? a_rpc : m_exp + 32'(4 * k);
                m_cyc++;
                if (m_cyc == MAX_A) m_state = ST_TO;
                else if (stop)      m_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                m_cyc++;
                m_drain++;
                if (m_cyc == MAX_A)          m_state = ST_TO;
                else if (m_drain == DRAIN_A) m_state = ST_DONE;
            end
            default: begin
                if (a_start) begin
                    m_state = ST_RUN; m_fc = 0; m_ec = 0; m_cyc = 0; m_drain = 0;
                    m_exp = 0; m_got = 0; m_want = 0; m_seen = 0;
                end
            end
        endcase
        m_pcerr = nxt_pcerr;
    endtask

    task automatic compare_all();
        check("state",       64'(bus_a.state_o),       64'(m_state));
        check("done",        64'(bus_a.done),          64'(m_state == ST_DONE));
        check("timeout",     64'(bus_a.timeout),       64'(m_state == ST_TO));
        check("pc_err",      64'(bus_a.pc_err),        64'(m_pcerr));
        check("err_count",   64'(bus_a.err_count),     64'(m_ec));
        check("fetch_count", 64'(bus_a.fetch_count),   64'(m_fc));
        check("err_got",     64'(bus_a.first_err_got), 64'(m_got));
        check("err_exp",     64'(bus_a.first_err_exp), 64'(m_want));
        check("exp_pc",      64'(bus_a.expected_pc),   64'(m_exp));
    endtask

    // driver tasks
    task automatic drive(input logic st, input logic [1:0] fire, input logic [31:0] p0, input logic [31:0] p1,
                         input logic [1:0] inv, input logic rv, input logic [31:0] rpc);
        a_start = st; a_fire = fire; a_p0 = p0; a_p1 = p1; a_inv = inv; a_rv = rv; a_rpc = rpc;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    endtask

    task automatic rand_cycle(input int n);
        int          r;
        logic [1:0]  fire, inv;
        logic [31:0] p0, p1;
        r = $urandom_range(0, 99);
        case ($urandom_range(0, 2))
            0:       fire = 2'b00;
            1:       fire = 2'b01;
            default: fire = 2'b11;
        endcase
        if (r < 5) fire = 2'b10;
        p0 = m_exp;
        p1 = m_exp + 32'd4;
        if (r >= 5 && r < 12)  p0 = $urandom;
        if (r >= 12 && r < 18) p1 = $urandom & 32'hFFFF_FFFC;
        inv = 2'b00;
        if (n > 40 && $urandom_range(0, 24) == 0) inv = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        drive($urandom_range(0, 19) == 0, fire, p0, p1, inv, $urandom_range(0, 9) == 0,
              $urandom & 32'hFFFF_FFFC);
    endtask

    task automatic random_run();
        int n;
        n = 0;
        while (m_state == ST_RUN && n < 150) begin rand_cycle(n); n++; end
        if (m_state == ST_RUN) drive(1'b0, 2'b01, m_exp, 32'h0, 2'b01, 1'b0, 32'h0);
        n = 0;
        while (m_state == ST_DRAIN && n < DRAIN_A + 5) begin
            drive(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom);
            n++;
        end
        check("rnd_done", 64'(bus_a.state_o), 64'(ST_DONE));
        drive(1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    endtask

    initial begin
        int wd_n;
        a_rst_n = 1'b0; a_start = 0; a_fire = 0; a_inv = 0; a_p0 = 0; a_p1 = 0; a_rv = 0; a_rpc = 0;
        b_rst_n = 1'b0; b_start = 1'b0;

        // watchdog instance: timeout exactly MAX_B cycles after start
        repeat (2) @(posedge clk);
        #1;
        check("b_reset_state", 64'(bus_b.state_o), 64'(ST_IDLE));
        b_rst_n = 1'b1; b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        check("b_run", 64'(bus_b.state_o), 64'(ST_RUN));
        wd_n = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus_b.timeout) begin wd_n = n; break; end
        end
        check("b_wd_cycles", 64'(wd_n), 64'(MAX_B));
        check("b_state_to", 64'(bus_b.state_o), 64'(ST_TO));
        check("b_not_done", 64'(bus_b.done), 64'(0));
        b_rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("b_reset_again", 64'({bus_b.state_o, bus_b.timeout}), 64'(0));

        // reset state of A
        idle(); idle();
        check("rst_state", 64'(bus_a.state_o), 64'(ST_IDLE));
        check("rst_exp_pc", 64'(bus_a.expected_pc), 64'(0));
        a_rst_n = 1'b1;
        drive(1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
        check("start_run", 64'(bus_a.state_o), 64'(ST_RUN));

        // sequential two-lane fetch
        drive(1'b0, 2'b11, 32'h0, 32'h4, 2'b00, 1'b0, 32'h0);
        drive(1'b0, 2'b11, 32'h8, 32'hC, 2'b00, 1'b0, 32'h0);
        idle();
        check("t1_fc", 64'(bus_a.fetch_count), 64'(4));
        check("t1_exp", 64'(bus_a.expected_pc), 64'h10);
        check("t1_err", 64'(bus_a.err_count), 64'(0));

        // redirect in the same cycle as a fire
        drive(1'b0, 2'b11, 32'h10, 32'h14, 2'b00, 1'b1, 32'h40);
        check("t2_redir", 64'(bus_a.expected_pc), 64'h40);
        drive(1'b0, 2'b11, 32'h40, 32'h44, 2'b00, 1'b0, 32'h0);
        idle();
        check("t2_exp", 64'(bus_a.expected_pc), 64'h48);
        check("t2_err", 64'(bus_a.err_count), 64'(0));

        // lane-1 mismatch, sticky capture, later error
        drive(1'b0, 2'b01, 32'h48, 32'h0, 2'b00, 1'b1, 32'h14);
        drive(1'b0, 2'b11, 32'h14, 32'h1C, 2'b00, 1'b0, 32'h0);
        check("t3_pc_err", 64'(bus_a.pc_err), 64'(1));
        check("t3_ec", 64'(bus_a.err_count), 64'(1));
        check("t3_got", 64'(bus_a.first_err_got), 64'h1C);
        check("t3_want", 64'(bus_a.first_err_exp), 64'h18);
        idle();
        check("t3_pulse_end", 64'(bus_a.pc_err), 64'(0));
        drive(1'b0, 2'b01, 32'h99, 32'h0, 2'b00, 1'b0, 32'h0);
        check("t3_ec2", 64'(bus_a.err_count), 64'(2));
        check("t3_sticky", 64'(bus_a.first_err_got), 64'h1C);

        // non-contiguous fire, then wrap-around
        drive(1'b0, 2'b10, 32'h0, 32'h24, 2'b00, 1'b0, 32'h0);
        check("t6_contig", 64'(bus_a.err_count), 64'(3));
        check("t6_exp", 64'(bus_a.expected_pc), 64'h24);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 32'hFFFF_FFFC);
        drive(1'b0, 2'b11, 32'hFFFF_FFFC, 32'h0, 2'b00, 1'b0, 32'h0);
        check("t6_wrap_err", 64'(bus_a.pc_err), 64'(0));
        check("t6_wrap_exp", 64'(bus_a.expected_pc), 64'h4);

        // invalid on lane 1, then drain
        drive(1'b0, 2'b11, 32'h4, 32'h8, 2'b10, 1'b0, 32'h0);
        check("t4_drain", 64'(bus_a.state_o), 64'(ST_DRAIN));
        check("t4_fc", 64'(bus_a.fetch_count), 64'(16));
        repeat (DRAIN_A - 1) idle();
        check("t4_still_drain", 64'(bus_a.state_o), 64'(ST_DRAIN));
        idle();
        check("t4_done", 64'(bus_a.done), 64'(1));

        // restart from DONE clears counters and sticky regs
        drive(1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
        check("restart_fc", 64'(bus_a.fetch_count), 64'(0));
        check("restart_got", 64'(bus_a.first_err_got), 64'(0));

        repeat (4) random_run();

        // reset in the middle of DRAIN
        drive(1'b0, 2'b01, m_exp, 32'h0, 2'b01, 1'b0, 32'h0);
        idle(); idle();
        a_rst_n = 1'b0;
        idle();
        check("mid_rst_state", 64'(bus_a.state_o), 64'(ST_IDLE));
        check("mid_rst_cnts", 64'({bus_a.fetch_count, bus_a.err_count, bus_a.pc_err}), 64'(0));
        check("mid_rst_regs", {bus_a.first_err_got, bus_a.first_err_exp}, 64'(0));
        a_rst_n = 1'b1;
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
